fft_ctrl64: RTL and testbench

//  Sequencer for 64-point FFT (8x8 decomposition) around two fft_core8 passes and a ping-pong buffer pair.

---
 rtl/fft_ctrl64_pkg.sv | 30 +++
 rtl/fft_ctrl64_if.sv | 39 +++
 rtl/fft_ctrl64_dly.sv | 26 ++
 rtl/fft_ctrl64.sv | 129 ++++++++++++
 tb/tb_fft_ctrl64.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/fft_ctrl64_pkg.sv
// rtl/fft_ctrl64_pkg.sv - shared constants, state encoding and delay-line record for the 64-point FFT sequencer
package fft_ctrl64_pkg;

    localparam int FFT_PNT = 64;
    localparam int GRP_NUM = 8;
    localparam int GRP_WD  = $clog2(GRP_NUM);

    localparam logic [GRP_WD-1:0] GRP_LAST = GRP_WD'(GRP_NUM - 1);

    localparam logic BUF_A    = 1'b0;
    localparam logic BUF_B    = 1'b1;
    localparam logic MODE_ROW = 1'b0;
    localparam logic MODE_COL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STG0,
        ST_STG1,
        ST_DUMP
    } state_t;

    // One in-flight core8 read, tracked until its result is written back
    typedef struct packed {
        logic              vld;
        logic [GRP_WD-1:0] grp;
        logic [GRP_WD-1:0] tw_grp;
    } dly_t;

endpackage

// File: rtl/fft_ctrl64_if.sv
// rtl/fft_ctrl64_if.sv - handshake, buffer and twiddle control bundle of the FFT sequencer
interface fft_ctrl64_if;
    import fft_ctrl64_pkg::*;

    logic              start;
    logic              busy;
    logic              done;
    logic              in_val;
    logic              in_rdy;
    logic              out_val;
    logic              out_rdy;
    logic              buf_rd_en;
    logic              buf_rd_sel;
    logic              buf_rd_mode;
    logic [GRP_WD-1:0] buf_rd_grp;
    logic              buf_wr_en;
    logic              buf_wr_sel;
    logic              buf_wr_mode;
    logic [GRP_WD-1:0] buf_wr_grp;
    logic              tw_en;
    logic [GRP_WD-1:0] tw_grp;

    modport master (
        input  start, in_val, out_rdy,
        output busy, done, in_rdy, out_val,
        output buf_rd_en, buf_rd_sel, buf_rd_mode, buf_rd_grp,
        output buf_wr_en, buf_wr_sel, buf_wr_mode, buf_wr_grp,
        output tw_en, tw_grp
    );

    modport slave (
        output start, in_val, out_rdy,
        input  busy, done, in_rdy, out_val,
        input  buf_rd_en, buf_rd_sel, buf_rd_mode, buf_rd_grp,
        input  buf_wr_en, buf_wr_sel, buf_wr_mode, buf_wr_grp,
        input  tw_en, tw_grp
    );

endinterface

// File: rtl/fft_ctrl64_dly.sv
// rtl/fft_ctrl64_dly.sv - LAT-stage shift register matching buffer-read issue to core-result write
module fft_ctrl64_dly
    import fft_ctrl64_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  dly_t d,
    output dly_t q
);

    dly_t pipe [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[LAT-1];

endmodule

// File: rtl/fft_ctrl64.sv
// rtl/fft_ctrl64.sv - 64-point FFT sequencer: load, column pass, row pass, dump over a ping-pong buffer pair
module fft_ctrl64 #(
    parameter int CORE_LAT = 2
) (
    input logic         clk,
    input logic         rst_n,
    fft_ctrl64_if.master bus
);
    import fft_ctrl64_pkg::*;

    state_t            state_q, state_d;
    logic [GRP_WD-1:0] grp_q, grp_d;
    logic              rd_done_q, rd_done_d;
    logic              done_q, done_d;
    dly_t              dly_in, dly_out;
    logic              stg0;

    assign stg0 = (state_q == ST_STG0);

    fft_ctrl64_dly #(.LAT(CORE_LAT)) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dly_in),
        .q     (dly_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grp_q     <= '0;
            rd_done_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grp_q     <= grp_d;
            rd_done_q <= rd_done_d;
            done_q    <= done_d;
        end
    end

    assign bus.done = done_q;
    assign bus.busy = (state_q != ST_IDLE);

    always_comb begin
        state_d         = state_q;
        grp_d           = grp_q;
        rd_done_d       = rd_done_q;
        done_d          = 1'b0;
        dly_in          = '0;
        bus.in_rdy      = 1'b0;
        bus.out_val     = 1'b0;
        bus.buf_rd_en   = 1'b0;
        bus.buf_rd_sel  = BUF_A;
        bus.buf_rd_mode = MODE_ROW;
        bus.buf_rd_grp  = '0;
        bus.buf_wr_en   = 1'b0;
        bus.buf_wr_sel  = BUF_A;
        bus.buf_wr_mode = MODE_ROW;
        bus.buf_wr_grp  = '0;
        bus.tw_en       = 1'b0;
        bus.tw_grp      = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_LOAD;
                    grp_d   = '0;
                end
            end

            ST_LOAD: begin
                bus.in_rdy = 1'b1;
                if (bus.in_val) begin
                    bus.buf_wr_en  = 1'b1;
                    bus.buf_wr_grp = grp_q;
                    grp_d          = grp_q + 1'b1;
                    if (grp_q == GRP_LAST) begin
                        state_d   = ST_STG0;
                        rd_done_d = 1'b0;
                    end
                end
            end

            ST_STG0, ST_STG1: begin
                // Reads go out back-to-back; the pass ends only when the last result has landed
                if (!rd_done_q) begin
                    bus.buf_rd_en   = 1'b1;
                    bus.buf_rd_sel  = stg0 ? BUF_A : BUF_B;
                    bus.buf_rd_mode = stg0 ? MODE_COL : MODE_ROW;
                    bus.buf_rd_grp  = grp_q;
                    dly_in.vld      = 1'b1;
                    dly_in.grp      = grp_q;
                    dly_in.tw_grp   = stg0 ? grp_q : '0;
                    grp_d           = grp_q + 1'b1;
                    rd_done_d       = (grp_q == GRP_LAST);
                end
                if (dly_out.vld) begin
                    bus.buf_wr_en   = 1'b1;
                    bus.buf_wr_sel  = stg0 ? BUF_B : BUF_A;
                    bus.buf_wr_mode = MODE_COL;
                    bus.buf_wr_grp  = dly_out.grp;
                    bus.tw_en       = stg0;
                    bus.tw_grp      = stg0 ? dly_out.tw_grp : '0;
                    if (dly_out.grp == GRP_LAST) begin
                        state_d   = stg0 ? ST_STG1 : ST_DUMP;
                        grp_d     = '0;
                        rd_done_d = 1'b0;
                    end
                end
            end

            ST_DUMP: begin
                bus.out_val    = 1'b1;
                bus.buf_rd_en  = 1'b1;
                bus.buf_rd_grp = grp_q;
                if (bus.out_rdy) begin
                    grp_d = grp_q + 1'b1;
                    if (grp_q == GRP_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fft_ctrl64.sv
// tb/tb_fft_ctrl64.sv - randomized frame-level bench for fft_ctrl64 against a per-cycle timing-rule model
module tb_fft_ctrl64;
    import fft_ctrl64_pkg::*;

    localparam int CL   = 2;
    localparam int MAXC = 256;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       in_rdy;
        logic       out_val;
        logic       rd_en;
        logic       rd_sel;
        logic       rd_mode;
        logic [2:0] rd_grp;
        logic       wr_en;
        logic       wr_sel;
        logic       wr_mode;
        logic [2:0] wr_grp;
        logic       tw_en;
        logic [2:0] tw_grp;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   fno    = 0;

    obs_t exp_w [MAXC];
    bit   ival  [MAXC];
    bit   ordy  [MAXC];
    bit   strt  [MAXC];

    fft_ctrl64_if bus ();

    fft_ctrl64 #(.CORE_LAT(CL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.busy    = bus.busy;
        o.done    = bus.done;
        o.in_rdy  = bus.in_rdy;
        o.out_val = bus.out_val;
        o.rd_en   = bus.buf_rd_en;
        o.rd_sel  = bus.buf_rd_sel;
        o.rd_mode = bus.buf_rd_mode;
        o.rd_grp  = bus.buf_rd_grp;
        o.wr_en   = bus.buf_wr_en;
        o.wr_sel  = bus.buf_wr_sel;
        o.wr_mode = bus.buf_wr_mode;
        o.wr_grp  = bus.buf_wr_grp;
        o.tw_en   = bus.tw_en;
        o.tw_grp  = bus.tw_grp;
        return o;
    endfunction

    // mode: 0 random gaps/stalls, 1 alternating input gaps, 2 three-cycle stall at grp 4, 3 clean
    task automatic run_frame(input int mode, input int gap_pct, input int stall_pct,
                             input bit hold, input bit chained,
                             output int first_obs, output int done_obs);
        int   k, c, s0, s1, d, done_c, nload, nout;
        obs_t got;
        fno++;
        for (int i = 0; i < MAXC; i++) begin
            exp_w[i] = '0;
            case (mode)
                0:       ival[i] = (i >= 60) || ($urandom_range(0, 99) >= gap_pct);
                1:       ival[i] = (i % 2 == 0);
                default: ival[i] = 1'b1;
            endcase
        end
        k = 0;
        c = 1;
        while (k < GRP_NUM) begin
            exp_w[c].busy   = 1'b1;
            exp_w[c].in_rdy = 1'b1;
            if (ival[c]) begin
                exp_w[c].wr_en  = 1'b1;
                exp_w[c].wr_grp = 3'(k);
                k++;
            end
            c++;
        end
        s0 = c;
        s1 = s0 + GRP_NUM + CL;
        d  = s1 + GRP_NUM + CL;
        for (int g = 0; g < GRP_NUM; g++) begin
            exp_w[s0+g].rd_en      = 1'b1;
            exp_w[s0+g].rd_mode    = 1'b1;
            exp_w[s0+g].rd_grp     = 3'(g);
            exp_w[s0+g+CL].wr_en   = 1'b1;
            exp_w[s0+g+CL].wr_sel  = 1'b1;
            exp_w[s0+g+CL].wr_mode = 1'b1;
            exp_w[s0+g+CL].wr_grp  = 3'(g);
            exp_w[s0+g+CL].tw_en   = 1'b1;
            exp_w[s0+g+CL].tw_grp  = 3'(g);
            exp_w[s1+g].rd_en      = 1'b1;
            exp_w[s1+g].rd_sel     = 1'b1;
            exp_w[s1+g].rd_grp     = 3'(g);
            exp_w[s1+g+CL].wr_en   = 1'b1;
            exp_w[s1+g+CL].wr_mode = 1'b1;
            exp_w[s1+g+CL].wr_grp  = 3'(g);
        end
        for (int i = s0; i < d; i++) exp_w[i].busy = 1'b1;
        for (int i = 0; i < MAXC; i++) begin
            case (mode)
                0:       ordy[i] = (i >= d + 40) || ($urandom_range(0, 99) >= stall_pct);
                2:       ordy[i] = !(i >= d + 4 && i <= d + 6);
                default: ordy[i] = 1'b1;
            endcase
        end
        k = 0;
        c = d;
        while (k < GRP_NUM) begin
            exp_w[c].busy    = 1'b1;
            exp_w[c].out_val = 1'b1;
            exp_w[c].rd_en   = 1'b1;
            exp_w[c].rd_grp  = 3'(k);
            if (ordy[c]) k++;
            c++;
        end
        done_c = c;
        exp_w[done_c].done = 1'b1;
        for (int i = 0; i < MAXC; i++)
            strt[i] = (i == 0) || ((i == done_c) ? hold : (hold || $urandom_range(0, 1) == 1));

        first_obs = -1;
        done_obs  = -1;
        nload     = 0;
        nout      = 0;
        for (int i = chained ? 1 : 0; i <= done_c; i++) begin
            @(negedge clk);
            bus.start   = strt[i];
            bus.in_val  = ival[i];
            bus.out_rdy = ordy[i];
            #1;
            got = sample();
            check($sformatf("f%0d_cyc%0d", fno, i), int'(got), int'(exp_w[i]));
            if (got.out_val && first_obs < 0) first_obs = i;
            if (got.done) done_obs = i;
            if (got.wr_en && !got.wr_sel && !got.wr_mode) nload++;
            if (got.out_val && ordy[i]) nout++;
        end
        check($sformatf("f%0d_load_writes", fno), nload, GRP_NUM);
        check($sformatf("f%0d_out_beats", fno), nout, GRP_NUM);
    endtask

    task automatic mid_reset(input int ncyc);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.in_val  = 1'b1;
        bus.out_rdy = 1'b1;
        repeat (ncyc) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check($sformatf("midrst%0d_outs", ncyc), int'(sample()), 0);
        check($sformatf("midrst%0d_busy", ncyc), int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int fo, dn;
        bit h, hold_prev;
        bus.start   = 1'b0;
        bus.in_val  = 1'b0;
        bus.out_rdy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outs", int'(sample()), 0);
        rst_n = 1'b1;

        run_frame(3, 0, 0, 1'b0, 1'b0, fo, dn);
        check("first_out_latency", fo, 29);
        check("done_after_first_out", dn - fo, 8);

        run_frame(1, 0, 0, 1'b0, 1'b0, fo, dn);

        run_frame(2, 0, 0, 1'b0, 1'b0, fo, dn);
        check("stall_done_gap", dn - fo, 11);

        run_frame(3, 0, 0, 1'b1, 1'b0, fo, dn);
        run_frame(3, 0, 0, 1'b0, 1'b1, fo, dn);
        check("chained_latency", fo, 29);

        mid_reset(3);
        run_frame(3, 0, 0, 1'b0, 1'b0, fo, dn);
        mid_reset(12);
        run_frame(3, 0, 0, 1'b0, 1'b0, fo, dn);
        check("post_stg_reset_latency", fo, 29);

        hold_prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            h = ($urandom_range(0, 1) == 1);
            run_frame(0, $urandom_range(0, 70), $urandom_range(0, 70), h, hold_prev, fo, dn);
            hold_prev = h;
        end
        if (hold_prev) run_frame(3, 0, 0, 1'b0, 1'b1, fo, dn);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d checks", n_chk);
        $fatal(1);
    end

endmodule
